avalon_reg_bank: RTL

//  Parametrised Avalon-MM slave register bank. Provides NUM_REGS byte-writable control

---
 rtl/avalon_reg_bank_pkg.sv | 16 +
 rtl/avalon_reg_bank_be_reg.sv | 38 +++
 rtl/avalon_reg_bank.sv | 104 ++++++++++
 3 files changed

// File: rtl/avalon_reg_bank_pkg.sv
// Shared definitions for Avalon-MM slave blocks: byte width and byte-lane mask expansion.
package avalon_reg_bank_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MAX_BYTES = 8;

  // Callers cast the result down to their own data width.
  function automatic logic [MAX_BYTES*BYTE_W-1:0] lane_mask(input logic [MAX_BYTES-1:0] be);
    logic [MAX_BYTES*BYTE_W-1:0] m;
    for (int b = 0; b < MAX_BYTES; b++) begin
      m[b*BYTE_W +: BYTE_W] = {BYTE_W{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/avalon_reg_bank_be_reg.sv
// Single register with per-byte-lane write enables and asynchronous active-high reset.
module be_reg
  import avalon_reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [DATA_W/BYTE_W-1:0] be_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        q_o
);

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] q_d, q_q;

  assign mask = DATA_W'(lane_mask(MAX_BYTES'(be_i)));

  always_comb begin
    q_d = q_q;
    if (we_i) begin
      q_d = (q_q & ~mask) | (wdata_i & mask);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/avalon_reg_bank.sv
// Avalon-MM register bank: byte-writable control registers, sticky W1C STATUS with level irq,
// and latency-1 registered reads.
module avalon_reg_bank
  import avalon_reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_REGS  = 4,
  parameter int unsigned       ADDR_W    = $clog2(NUM_REGS + 1),
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [ADDR_W-1:0]          address_i,
  input  logic                       chipselect_i,
  input  logic                       read_i,
  input  logic                       write_i,
  input  logic [DATA_W/BYTE_W-1:0]   byteenable_i,
  input  logic [DATA_W-1:0]          writedata_i,
  output logic [DATA_W-1:0]          readdata_o,
  output logic                       readdatavalid_o,
  input  logic [DATA_W-1:0]          event_in_i,
  output logic                       irq_o,
  output logic [NUM_REGS*DATA_W-1:0] q_export_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  logic                wr_en, rd_en, status_hit;
  logic [NUM_REGS-1:0] reg_hit;
  logic [DATA_W-1:0]   q_arr [NUM_REGS];
  logic [DATA_W-1:0]   wmask, clr, rd_mux;

  logic [DATA_W-1:0]   status_d, status_q;
  logic [DATA_W-1:0]   readdata_d, readdata_q;
  logic                rdv_q, irq_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  assign wr_en      = chipselect_i & write_i;
  assign rd_en      = chipselect_i & read_i;
  assign status_hit = address_i == ADDR_W'(NUM_REGS);
  assign wmask      = DATA_W'(lane_mask(MAX_BYTES'(byteenable_i)));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign reg_hit[i] = wr_en && (address_i == ADDR_W'(i));

    be_reg #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_be_reg (
      .clk_i   (clk_i),
      .rst_i   (reset_i),
      .we_i    (reg_hit[i]),
      .be_i    (byteenable_i),
      .wdata_i (writedata_i),
      .q_o     (q_arr[i])
    );

    assign q_export_o[i*DATA_W +: DATA_W] = q_arr[i];
  end

  // Events are OR-ed in after the clear so a same-cycle set survives.
  always_comb begin
    clr = '0;
    if (wr_en && status_hit) begin
      clr = writedata_i & wmask;
    end
    status_d = (status_q & ~clr) | event_in_i;
  end

  // Mux uses current register state, so a same-cycle write returns the old value.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address_i == ADDR_W'(i)) begin
        rd_mux = q_arr[i];
      end
    end
    if (status_hit) begin
      rd_mux = status_q;
    end
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      status_q   <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      status_q   <= status_d;
      irq_q      <= |status_d;
      readdata_q <= readdata_d;
      rdv_q      <= rd_en;
      wr_pulse_q <= reg_hit;
    end
  end

  assign readdata_o      = readdata_q;
  assign readdatavalid_o = rdv_q;
  assign irq_o           = irq_q;
  assign wr_pulse_o      = wr_pulse_q;

endmodule
